// File: rtl/mips_pkg.sv
// Shared MIPS opcode constants, sequencer state encoding and pipeline-control helpers.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BLTZ   = OP_REGIMM;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] FUNCT_JR  = 6'b001000;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_TIMEOUT  = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic pipe_hold;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_HOLD = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                       idex_bubble: 1'b0, pipe_hold: 1'b1};
  localparam pipe_ctrl_t CTRL_RESET = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1,
                                        idex_bubble: 1'b1, pipe_hold: 1'b0};

  // Control-flow and data-hazard resolution once memory is not holding the pipe.
  function automatic pipe_ctrl_t resolve_flow(input logic branch_taken, input logic jump,
                                              input logic load_use);
    pipe_ctrl_t c;
    c = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, idex_bubble: 1'b0, pipe_hold: 1'b0};
    if (branch_taken) begin
      c.ifid_write  = 1'b0;
      c.ifid_flush  = 1'b1;
      c.idex_bubble = 1'b1;
    end else if (jump) begin
      c.ifid_write = 1'b0;
      c.ifid_flush = 1'b1;
    end else if (load_use) begin
      c.pc_write    = 1'b0;
      c.ifid_write  = 1'b0;
      c.idex_bubble = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a lw in EX whose destination is read by the instruction in ID.
module hazard_detect
  import mips_pkg::*;
(
  input  logic [5:0] id_op,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [5:0] ex_op,
  input  logic [4:0] ex_rt,
  output logic       load_use
);

  logic rs_hit;
  logic rt_hit;

  // j carries a target in the rs field; only R-type and sw actually read rt.
  always_comb begin
    rs_hit   = (id_rs == ex_rt) && (id_op != OP_J);
    rt_hit   = (id_rt == ex_rt) && ((id_op == OP_RTYPE) || (id_op == OP_SW));
    load_use = (ex_op == OP_LW) && (ex_rt != 5'd0) && (rs_hit || rt_hit);
  end

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: zero-latency stall/flush control plus a memory-wait FSM
// with sticky timeout and a saturating stall-cycle counter.
module hazard_sequencer
  import mips_pkg::*;
#(
  parameter int WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_instr,
  input  logic [31:0] ex_instr,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        pipe_hold,
  output logic        mem_timeout,
  output logic [15:0] stall_cycles,
  output logic [1:0]  state
);

  localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

  seq_state_t  state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_timeout_q, mem_timeout_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic        load_use;
  pipe_ctrl_t  ctrl;
  logic        unused_bits;

  assign unused_bits = ^{id_instr[15:0], ex_instr[25:21], ex_instr[15:0]};

  hazard_detect u_hazard_detect (
    .id_op    (id_instr[31:26]),
    .id_rs    (id_instr[25:21]),
    .id_rt    (id_instr[20:16]),
    .ex_op    (ex_instr[31:26]),
    .ex_rt    (ex_instr[20:16]),
    .load_use (load_use)
  );

  // Branch/jump/load-use are only looked at when memory is not holding the pipe.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    ctrl          = resolve_flow(branch_taken, jump, load_use);
    case (state_q)
      ST_RUN: begin
        if (mem_req && !mem_ready) begin
          ctrl       = CTRL_HOLD;
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          state_d    = ST_RUN;
          wait_cnt_d = 8'd0;
        end else begin
          ctrl = CTRL_HOLD;
          if (wait_cnt_q == LIMIT) begin
            state_d       = ST_TIMEOUT;
            mem_timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
      end
      ST_TIMEOUT: begin
        ctrl          = CTRL_HOLD;
        mem_timeout_d = 1'b1;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = 8'd0;
      end
    endcase
    if (rst) begin
      ctrl = CTRL_RESET;
    end

    stall_cycles_d = stall_cycles_q;
    if (!rst && !ctrl.pc_write && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      wait_cnt_q     <= 8'd0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign pc_write     = ctrl.pc_write;
  assign ifid_write   = ctrl.ifid_write;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_bubble  = ctrl.idex_bubble;
  assign pipe_hold    = ctrl.pipe_hold;
  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_cycles_q;
  assign state        = state_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: hazards, priorities, memory wait, timeout and counter saturation.
module tb_hazard_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_instr;
  logic [31:0] ex_instr;
  logic        branch_taken;
  logic        jump;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        pipe_hold;
  logic        mem_timeout;
  logic [15:0] stall_cycles;
  logic [1:0]  state;

  int checkCount = 0;
  int errorCount = 0;

  // Expected control vectors, ordered {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold}
  localparam logic [4:0] C_RESET  = 5'b00110;
  localparam logic [4:0] C_NORMAL = 5'b11000;
  localparam logic [4:0] C_HOLD   = 5'b00001;
  localparam logic [4:0] C_LDUSE  = 5'b00010;
  localparam logic [4:0] C_BRANCH = 5'b10110;
  localparam logic [4:0] C_JUMP   = 5'b10100;

  hazard_sequencer #(.WAIT_LIMIT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_instr     (id_instr),
    .ex_instr     (ex_instr),
    .branch_taken (branch_taken),
    .jump         (jump),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .pipe_hold    (pipe_hold),
    .mem_timeout  (mem_timeout),
    .stall_cycles (stall_cycles),
    .state        (state)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mkInstr(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] low);
    return {op, rs, rt, low};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkCtrl(input string tag, input logic [4:0] expected);
    checkOutput(tag, {27'd0, pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold},
                {27'd0, expected});
  endtask

  task automatic applyStimulus(input logic [31:0] idI, input logic [31:0] exI, input logic br,
                               input logic jmp, input logic mreq, input logic mrdy);
    id_instr     = idI;
    ex_instr     = exI;
    branch_taken = br;
    jump         = jmp;
    mem_req      = mreq;
    mem_ready    = mrdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input string tag);
    rst = 1'b1;
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkCtrl({tag, "_rst_ctrl"}, C_RESET);
    tick();
    tick();
    checkOutput({tag, "_rst_stall"}, {16'd0, stall_cycles}, 32'd0);
    checkOutput({tag, "_rst_state"}, {30'd0, state}, 32'd0);
    checkOutput({tag, "_rst_tmo"}, {31'd0, mem_timeout}, 32'd0);
    rst = 1'b0;
    #1;
  endtask

  logic [31:0] lw5, lw0, subu352, subu300, sw5, addi5;

  initial begin
    lw5     = mkInstr(6'b100011, 5'd0, 5'd5, 16'd0);
    lw0     = mkInstr(6'b100011, 5'd0, 5'd0, 16'd4);
    subu352 = mkInstr(6'b000000, 5'd5, 5'd2, {5'd3, 5'd0, 6'b100011});
    subu300 = mkInstr(6'b000000, 5'd0, 5'd0, {5'd3, 5'd0, 6'b100011});
    sw5     = mkInstr(6'b101011, 5'd1, 5'd5, 16'd8);
    addi5   = mkInstr(6'b001000, 5'd1, 5'd5, 16'd1);

    doReset("init");

    applyStimulus(subu352, lw5, 1'b0, 1'b0, 1'b0, 1'b0);
    checkCtrl("lduse_stall", C_LDUSE);
    tick();
    applyStimulus(subu352, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkCtrl("lduse_after", C_NORMAL);
    checkOutput("lduse_count", {16'd0, stall_cycles}, 32'd1);

    applyStimulus(subu300, lw0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkCtrl("rt0_nostall", C_NORMAL);
    applyStimulus(sw5, lw5, 1'b0, 1'b0, 1'b0, 1'b0);
    checkCtrl("sw_rt_stall", C_LDUSE);
    applyStimulus(addi5, lw5, 1'b0, 1'b0, 1'b0, 1'b0);
    checkCtrl("addi_rt_nostall", C_NORMAL);
    tick();
    checkOutput("count_after_rt", {16'd0, stall_cycles}, 32'd1);

    applyStimulus(subu352, lw5, 1'b1, 1'b0, 1'b0, 1'b0);
    checkCtrl("branch_over_lduse", C_BRANCH);
    applyStimulus(subu352, lw5, 1'b0, 1'b1, 1'b0, 1'b0);
    checkCtrl("jump_over_lduse", C_JUMP);
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkCtrl("jump_only", C_JUMP);

    doReset("mw");
    applyStimulus(subu352, lw5, 1'b1, 1'b0, 1'b1, 1'b0);
    checkCtrl("mw_c1_hold", C_HOLD);
    checkOutput("mw_c1_state", {30'd0, state}, 32'd0);
    for (int k = 2; k <= 3; k++) begin
      tick();
      checkCtrl($sformatf("mw_c%0d_hold", k), C_HOLD);
      checkOutput($sformatf("mw_c%0d_state", k), {30'd0, state}, 32'd1);
    end
    tick();
    applyStimulus(subu352, lw5, 1'b1, 1'b0, 1'b1, 1'b1);
    checkCtrl("mw_release", C_BRANCH);
    checkOutput("mw_release_state", {30'd0, state}, 32'd1);
    checkOutput("mw_stall", {16'd0, stall_cycles}, 32'd3);
    tick();
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("mw_back_run", {30'd0, state}, 32'd0);
    checkCtrl("mw_back_normal", C_NORMAL);

    doReset("tmo");
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      checkOutput($sformatf("tmo_wait%0d_state", k), {30'd0, state}, 32'd1);
    end
    checkOutput("tmo_not_yet", {31'd0, mem_timeout}, 32'd0);
    tick();
    checkOutput("tmo_state", {30'd0, state}, 32'd2);
    checkOutput("tmo_flag", {31'd0, mem_timeout}, 32'd1);
    checkOutput("tmo_stall", {16'd0, stall_cycles}, 32'd5);
    applyStimulus(subu352, lw5, 1'b1, 1'b1, 1'b0, 1'b1);
    checkCtrl("tmo_ignores_inputs", C_HOLD);

    repeat (70000) @(posedge clk);
    #1;
    checkOutput("sat_value", {16'd0, stall_cycles}, 32'h0000FFFF);
    tick();
    tick();
    tick();
    checkOutput("sat_hold", {16'd0, stall_cycles}, 32'h0000FFFF);
    checkOutput("sat_tmo_sticky", {31'd0, mem_timeout}, 32'd1);
    checkOutput("sat_state", {30'd0, state}, 32'd2);

    doReset("clr");
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkCtrl("clr_normal", C_NORMAL);
    tick();
    checkOutput("clr_tmo", {31'd0, mem_timeout}, 32'd0);
    checkOutput("clr_stall", {16'd0, stall_cycles}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
